// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: Moore FSM driving every datapath enable and mux
// select. Outputs depend only on state (plus Zero for PCEn) and are held low in reset.
module mips_mc_control #(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 0,
    DECODE  = 1,
    MEMADR  = 2,
    MEMRD   = 3,
    MEMWB   = 4,
    MEMWR   = 5,
    EXECUTE = 6,
    ALUWB   = 7,
    BRANCH  = 8,
    ADDIEX  = 9,
    ADDIWB  = 10,
    JUMP    = 11,
    ILLEGAL = 12
  } state_t;

  state_t     state_q, state_d;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       pcwrite, branch, illegal;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = FETCH;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      ILLEGAL: illegal = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // Reset masks every output combinationally so no enable can pulse while it is held.
  assign {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
          ALUSrcB, ALUOp, PCSrc, PCEn, Illegal} =
    Reset ? '0 : {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, aluop, pcsrc, pcwrite | (branch & Zero), illegal};

  assign State = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control: per-opcode state sequences and a per-state
// output table predict every output each cycle, plus a few literal spot checks.
module tb_mips_mc_control;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] Op = 6'h00;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, Illegal;
  logic [3:0] State;

  mips_mc_control #(.STATE_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .Illegal(Illegal), .State(State)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit in_reset = 1'b0;
  int exp_state = 0;
  int seq[$];

  // Output order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
  // ALUSrcB[2] ALUOp[2] PCSrc[2] PCEn Illegal
  function automatic logic [14:0] exp_out(input int st, input logic z);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pcen = 0, ill = 0;
    logic [1:0] sb = 0, aop = 0, psrc = 0;
    case (st)
      0:     begin irw = 1; pcen = 1; sb = 2'b01; end
      1:     sb = 2'b11;
      2, 9:  begin sa = 1; sb = 2'b10; end
      3:     iord = 1;
      4:     begin m2r = 1; rw = 1; end
      5:     begin iord = 1; mw = 1; end
      6:     begin sa = 1; aop = 2'b10; end
      7:     begin rd = 1; rw = 1; end
      8:     begin sa = 1; aop = 2'b01; psrc = 2'b01; pcen = z; end
      10:    rw = 1;
      11:    begin psrc = 2'b10; pcen = 1; end
      12:    ill = 1;
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, psrc, pcen, ill};
  endfunction

  function automatic logic [14:0] dut_out();
    return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, PCEn, Illegal};
  endfunction

  task automatic load_seq(input logic [5:0] op);
    case (op)
      6'h23:   seq = '{0, 1, 2, 3, 4};
      6'h2B:   seq = '{0, 1, 2, 5};
      6'h00:   seq = '{0, 1, 6, 7};
      6'h08:   seq = '{0, 1, 9, 10};
      6'h04:   seq = '{0, 1, 8};
      6'h02:   seq = '{0, 1, 11};
      default: seq = '{0, 1, 12};
    endcase
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      logic [14:0] e;
      int es;
      e  = in_reset ? 15'd0 : exp_out(exp_state, Zero);
      es = in_reset ? 0 : exp_state;
      vectors++;
      if (dut_out() !== e || State !== es[3:0]) begin
        miscompares++;
        $display("FAIL cycle st=%0d: outs=%b state=%0d expected outs=%b state=%0d at %0t",
                 es, dut_out(), State, e, es, $time);
      end
    end
  end

  // zmode: 0/1 forces Zero in BRANCH, 2 randomizes; lits enables spot checks.
  // stop_at_memwr aborts the instruction with a mid-cycle reset in MEMWR.
  task automatic run_instr(input logic [5:0] op, input int zmode, input bit lits,
                           input bit stop_at_memwr);
    load_seq(op);
    foreach (seq[i]) begin
      exp_state = seq[i];
      Op = (seq[i] == 1 || seq[i] == 2) ? op : 6'($urandom);
      Zero = (seq[i] == 8 && zmode < 2) ? zmode[0] : 1'($urandom);
      @(negedge Clk);
      #1;
      if (lits) begin
        case (seq[i])
          0:  lit("fetch_pcen_irwrite", {14'd0, PCEn, IRWrite}, 16'h3);
          3:  lit("memrd_iord", {15'd0, IorD}, 16'h1);
          4:  lit("memwb_m2r_rw", {14'd0, MemtoReg, RegWrite}, 16'h3);
          5:  lit("memwr_mw_iord", {14'd0, MemWrite, IorD}, 16'h3);
          6:  lit("execute_aluop", {14'd0, ALUOp}, 16'h2);
          7:  lit("aluwb_regdst", {15'd0, RegDst}, 16'h1);
          8:  lit("branch_pcen_pcsrc_aluop", {11'd0, PCEn, PCSrc, ALUOp}, {11'd0, zmode[0], 4'b0101});
          9:  lit("addiex_alusrcb", {14'd0, ALUSrcB}, 16'h2);
          10: lit("addiwb_regdst", {15'd0, RegDst}, 16'h0);
          11: lit("jump_pcsrc_pcen", {13'd0, PCSrc, PCEn}, 16'h5);
          12: lit("illegal_pulse", {15'd0, Illegal}, 16'h1);
          default: ;
        endcase
      end
      if (stop_at_memwr && seq[i] == 5) begin
        #1;
        Reset = 1'b1;
        in_reset = 1'b1;
        #1;
        lit("async_reset_memwrite", {15'd0, MemWrite}, 16'h0);
        lit("async_reset_state", {12'd0, State}, 16'h0);
        @(negedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        in_reset = 1'b0;
        exp_state = 0;
        return;
      end
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] legal [6] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02};
    #1;
    Reset = 1'b1;
    in_reset = 1'b1;
    chk_en = 1'b1;
    #1;
    lit("reset_state", {12'd0, State}, 16'h0);
    lit("reset_pcen_irwrite", {14'd0, PCEn, IRWrite}, 16'h0);
    repeat (2) @(negedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    in_reset = 1'b0;
    exp_state = 0;

    run_instr(6'h23, 2, 1'b1, 1'b0);
    run_instr(6'h2B, 2, 1'b1, 1'b0);
    run_instr(6'h00, 2, 1'b1, 1'b0);
    run_instr(6'h08, 2, 1'b1, 1'b0);
    run_instr(6'h04, 0, 1'b1, 1'b0);
    run_instr(6'h04, 1, 1'b1, 1'b0);
    run_instr(6'h02, 2, 1'b1, 1'b0);
    run_instr(6'h3F, 2, 1'b1, 1'b0);
    run_instr(6'h2B, 2, 1'b0, 1'b1);
    run_instr(6'h23, 2, 1'b1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 5)] : 6'($urandom);
      run_instr(op, 2, 1'b0, ($urandom_range(0, 19) == 0));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
